// File: rtl/intadd_cru_issuer.sv
// Issue-side sequencer for the intadd unit: accepts one vector-add request,
// streams operand triples onto src_reg0/1/2 with a packed cru_intadd word,
// captures the unit results after INTADD_LAT cycles and returns them in
// order through a credit-protected result FIFO.
module intadd_cru_issuer #(
  parameter int INTADD_LAT = 1,
  parameter int RES_DEPTH  = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_mode,
  input  logic [2:0]   req_sign,
  input  logic         req_update_st,
  input  logic [3:0]   req_len,
  input  logic         opd_valid,
  output logic         opd_ready,
  input  logic [127:0] opd_src0,
  input  logic [127:0] opd_src1,
  input  logic [127:0] opd_src2,
  output logic [127:0] src_reg0,
  output logic [127:0] src_reg1,
  output logic [127:0] src_reg2,
  output logic [10:0]  cru_intadd,
  input  logic [127:0] dst_reg0,
  input  logic [127:0] dst_reg1,
  input  logic [127:0] st,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [127:0] res_dst0,
  output logic [127:0] res_dst1,
  output logic [127:0] res_st,
  output logic         res_last,
  output logic         busy
);

  localparam int PW = $clog2(RES_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic           mode_q;
  logic [2:0]     sign_q;
  logic           upd_q;
  logic [4:0]     len_q;
  logic [4:0]     issued_q;
  logic           beat_last_q;

  logic [CW-1:0]  inflight;
  logic [CW-1:0]  fifo_count;
  logic [CW:0]    outstanding;
  logic           credit_ok;

  logic           req_fire;
  logic           opd_fire;
  logic           push;
  logic           pop;
  logic           final_beat;

  logic [1:0]     prec;
  logic [10:0]    cru_word;

  logic [INTADD_LAT-1:0] vpipe;
  logic [INTADD_LAT-1:0] lpipe;

  logic [127:0]   mem_d0   [RES_DEPTH];
  logic [127:0]   mem_d1   [RES_DEPTH];
  logic [127:0]   mem_st   [RES_DEPTH];
  logic           mem_last [RES_DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;

  // Credit: never let issued-but-unpopped beats exceed the FIFO depth.
  assign outstanding = {1'b0, inflight} + {1'b0, fifo_count};
  assign credit_ok   = outstanding < (CW+1)'(RES_DEPTH);

  assign req_fire   = req_valid && req_ready;
  assign opd_fire   = opd_valid && opd_ready;
  assign push       = vpipe[INTADD_LAT-1];
  assign pop        = res_valid && res_ready;
  assign final_beat = (issued_q + 5'd1) == len_q;
  assign busy       = (state != IDLE);

  // In 32-bit mode sign_s2 has no meaning and is forced low.
  assign prec     = mode_q ? 2'b11 : 2'b00;
  assign cru_word = {1'b1, prec, prec, prec, sign_q[2], sign_q[1],
                     sign_q[0] & ~mode_q, upd_q};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and handshake readiness.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    opd_ready  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = ISSUE;
      end
      ISSUE: begin
        opd_ready = credit_ok;
        if (opd_valid && credit_ok && final_beat) state_next = DRAIN;
      end
      DRAIN: begin
        if (pop && res_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Latch request fields on acceptance and count issued beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q   <= 1'b0;
      sign_q   <= 3'd0;
      upd_q    <= 1'b0;
      len_q    <= 5'd0;
      issued_q <= 5'd0;
    end else if (req_fire) begin
      mode_q   <= req_mode;
      sign_q   <= req_sign;
      upd_q    <= req_update_st;
      len_q    <= (req_len == 4'd0) ? 5'd16 : {1'b0, req_len};
      issued_q <= 5'd0;
    end else if (opd_fire) begin
      issued_q <= issued_q + 5'd1;
    end
  end

  // Present one registered beat per operand handshake; cru is zero otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      src_reg0    <= '0;
      src_reg1    <= '0;
      src_reg2    <= '0;
      cru_intadd  <= '0;
      beat_last_q <= 1'b0;
    end else begin
      cru_intadd  <= opd_fire ? cru_word : 11'd0;
      beat_last_q <= opd_fire && final_beat;
      if (opd_fire) begin
        src_reg0 <= opd_src0;
        src_reg1 <= opd_src1;
        src_reg2 <= opd_src2;
      end
    end
  end

  // Track each presented beat through the unit latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      vpipe <= '0;
      lpipe <= '0;
    end else begin
      vpipe[0] <= cru_intadd[10];
      lpipe[0] <= beat_last_q;
      for (int i = 1; i < INTADD_LAT; i++) begin
        vpipe[i] <= vpipe[i-1];
        lpipe[i] <= lpipe[i-1];
      end
    end
  end

  // Beats in the unit and results waiting in the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight   <= '0;
      fifo_count <= '0;
    end else begin
      inflight   <= inflight + CW'(opd_fire) - CW'(push);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end

  // Result storage; contents are only visible through the head while non-empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_d0[wr_ptr]   <= dst_reg0;
      mem_d1[wr_ptr]   <= dst_reg1;
      mem_st[wr_ptr]   <= st;
      mem_last[wr_ptr] <= lpipe[INTADD_LAT-1];
    end
  end

  // FIFO pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  assign res_valid = (fifo_count != '0);
  assign res_dst0  = res_valid ? mem_d0[rd_ptr] : '0;
  assign res_dst1  = res_valid ? mem_d1[rd_ptr] : '0;
  assign res_st    = res_valid ? mem_st[rd_ptr] : '0;
  assign res_last  = res_valid && mem_last[rd_ptr];

endmodule

// File: tb/tb_intadd_cru_issuer.sv
// Self-checking bench for intadd_cru_issuer: emulates the intadd unit and
// predicts beats and results from a queue-based transaction model.
module tb_intadd_cru_issuer;

  localparam int LAT   = 1;
  localparam int DEPTH = 4;

  logic         clk;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic         req_mode;
  logic [2:0]   req_sign;
  logic         req_update_st;
  logic [3:0]   req_len;
  logic         opd_valid;
  logic         opd_ready;
  logic [127:0] opd_src0, opd_src1, opd_src2;
  logic [127:0] src_reg0, src_reg1, src_reg2;
  logic [10:0]  cru_intadd;
  logic [127:0] dst_reg0, dst_reg1, st;
  logic         res_valid;
  logic         res_ready;
  logic [127:0] res_dst0, res_dst1, res_st;
  logic         res_last;
  logic         busy;

  intadd_cru_issuer #(.INTADD_LAT(LAT), .RES_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_sign(req_sign), .req_update_st(req_update_st), .req_len(req_len),
    .opd_valid(opd_valid), .opd_ready(opd_ready),
    .opd_src0(opd_src0), .opd_src1(opd_src1), .opd_src2(opd_src2),
    .src_reg0(src_reg0), .src_reg1(src_reg1), .src_reg2(src_reg2),
    .cru_intadd(cru_intadd),
    .dst_reg0(dst_reg0), .dst_reg1(dst_reg1), .st(st),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_dst0(res_dst0), .res_dst1(res_dst1), .res_st(res_st),
    .res_last(res_last), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] d0;
    logic [127:0] d1;
    logic [127:0] st;
    bit           last;
    int           rdy;
  } exp_t;

  int compared;
  int mismatched;
  int cyc;
  int dut_beats;

  exp_t     q[$];
  bit       active;
  int       m_len;
  int       m_issued;
  bit       m_mode;
  bit [2:0] m_sign;
  bit       m_upd;

  int           opd_pat;
  bit           rr_rand;
  int           rr_hold;
  bit           fixed_ops;
  logic [127:0] fix0, fix1, fix2;
  logic [127:0] pend0, pend1, pend2;
  logic [10:0]  last_cru;
  logic [127:0] last_d0, last_st;

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [10:0] pack_cru(input bit mode, input bit [2:0] sign, input bit upd);
    if (mode) return {1'b1, 6'b111111, sign[2], sign[1], 1'b0, upd};
    return {1'b1, 6'b000000, sign[2], sign[1], sign[0], upd};
  endfunction

  // Behaviour of the emulated unit: lane adds with overflow flags, cru echoed in st.
  function automatic void unit_fn(input logic [127:0] s0, input logic [127:0] s1,
                                  input logic [127:0] s2, input logic [10:0] cru,
                                  output logic [127:0] d0, output logic [127:0] d1,
                                  output logic [127:0] so);
    logic [31:0] a, b, sm;
    d0 = '0; d1 = '0; so = '0;
    if (cru[9:8] == 2'b11) begin
      for (int i = 0; i < 4; i++) begin
        a = s0[32*i +: 32];
        b = s1[32*i +: 32];
        sm = a + b;
        d0[32*i +: 32] = sm;
        d1[32*i +: 32] = a - b;
        so[32*i] = (a[31] == b[31]) && (sm[31] != a[31]);
      end
    end else begin
      for (int i = 0; i < 16; i++) begin
        d0[8*i +: 8] = s0[8*i +: 8] + s1[8*i +: 8] + s2[8*i +: 8];
        d1[8*i +: 8] = s0[8*i +: 8] ^ s1[8*i +: 8] ^ s2[8*i +: 8];
      end
    end
    so[127:117] = cru;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  // Unit emulation: results valid exactly LAT cycles after a beat, junk otherwise.
  task automatic unitTick();
    dst_reg0 = pend0;
    dst_reg1 = pend1;
    st       = pend2;
    if (cru_intadd[10]) unit_fn(src_reg0, src_reg1, src_reg2, cru_intadd, pend0, pend1, pend2);
    else begin
      pend0 = rnd128();
      pend1 = rnd128();
      pend2 = rnd128();
    end
  endtask

  // One clock cycle: drive, check combinational outputs, clock, check beat, update model.
  task automatic applyStimulus();
    bit           exp_rv, exp_ordy, fire_req, fire_opd, fire_pop;
    logic [10:0]  exp_cru;
    logic [127:0] o0, o1, o2, e0, e1, es;
    exp_t         ent;
    int           c;
    case (opd_pat)
      0:       opd_valid = 1'b1;
      1:       opd_valid = cyc[0];
      default: opd_valid = 1'($urandom_range(0, 1));
    endcase
    if (fixed_ops) begin
      opd_src0 = fix0; opd_src1 = fix1; opd_src2 = fix2;
    end else begin
      opd_src0 = rnd128(); opd_src1 = rnd128(); opd_src2 = rnd128();
    end
    if (rr_hold > 0) begin
      res_ready = 1'b0;
      rr_hold--;
    end else if (rr_rand) res_ready = 1'($urandom_range(0, 1));
    else res_ready = 1'b1;
    #1;
    exp_rv   = (q.size() > 0) && (q[0].rdy <= cyc);
    exp_ordy = active && (m_issued < m_len) && (q.size() < DEPTH);
    checkOutput("req_ready", req_ready, !active);
    checkOutput("opd_ready", opd_ready, exp_ordy);
    checkOutput("res_valid", res_valid, exp_rv);
    checkOutput("busy", busy, active);
    if (exp_rv) begin
      checkOutput("res_dst0", res_dst0, q[0].d0);
      checkOutput("res_dst1", res_dst1, q[0].d1);
      checkOutput("res_st", res_st, q[0].st);
      checkOutput("res_last", res_last, q[0].last);
    end
    fire_req = req_valid && !active;
    fire_opd = opd_valid && exp_ordy;
    fire_pop = exp_rv && res_ready;
    if (fire_pop) begin
      last_d0 = res_dst0;
      last_st = res_st;
    end
    exp_cru = pack_cru(m_mode, m_sign, m_upd);
    o0 = opd_src0; o1 = opd_src1; o2 = opd_src2;
    c = cyc;
    @(posedge clk);
    #1;
    cyc++;
    unitTick();
    if (cru_intadd[10]) begin
      dut_beats++;
      last_cru = cru_intadd;
    end
    if (fire_opd) begin
      checkOutput("cru_beat", cru_intadd, exp_cru);
      checkOutput("src_reg0", src_reg0, o0);
      checkOutput("src_reg1", src_reg1, o1);
      checkOutput("src_reg2", src_reg2, o2);
    end else begin
      checkOutput("cru_gap", cru_intadd, 11'd0);
    end
    if (fire_pop) begin
      ent = q.pop_front();
      if (ent.last) active = 1'b0;
    end
    if (fire_opd) begin
      unit_fn(o0, o1, o2, exp_cru, e0, e1, es);
      ent.d0 = e0; ent.d1 = e1; ent.st = es;
      ent.last = (m_issued == m_len - 1);
      ent.rdy = c + LAT + 2;
      q.push_back(ent);
      m_issued++;
    end
    if (fire_req) begin
      active   = 1'b1;
      m_mode   = req_mode;
      m_sign   = req_sign;
      m_upd    = req_update_st;
      m_len    = (req_len == 4'd0) ? 16 : int'(req_len);
      m_issued = 0;
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    req_valid = 1'b0;
    opd_valid = 1'b0;
    res_ready = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    unitTick();
    rst = 1'b0;
    q.delete();
    active = 1'b0;
    m_issued = 0;
    checkOutput("rst_cru", cru_intadd, 11'd0);
    checkOutput("rst_src0", src_reg0, 128'd0);
    checkOutput("rst_src1", src_reg1, 128'd0);
    checkOutput("rst_src2", src_reg2, 128'd0);
    checkOutput("rst_res_valid", res_valid, 1'b0);
    checkOutput("rst_res_dst0", res_dst0, 128'd0);
    checkOutput("rst_res_st", res_st, 128'd0);
    checkOutput("rst_res_last", res_last, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_req_ready", req_ready, 1'b1);
    checkOutput("rst_opd_ready", opd_ready, 1'b0);
  endtask

  task automatic runRequest(input bit mode, input logic [2:0] sign, input bit upd,
                            input logic [3:0] len, input int budget);
    int n;
    req_mode = mode; req_sign = sign; req_update_st = upd; req_len = len;
    req_valid = 1'b1;
    n = 0;
    while (!active && n < budget) begin applyStimulus(); n++; end
    req_valid = 1'b0;
    while (active && n < budget) begin applyStimulus(); n++; end
    checkOutput("run_done_busy", busy, 1'b0);
  endtask

  initial begin
    int b, n;
    compared = 0; mismatched = 0; cyc = 0; dut_beats = 0;
    active = 1'b0; m_len = 0; m_issued = 0; m_mode = 1'b0; m_sign = 3'd0; m_upd = 1'b0;
    opd_pat = 0; rr_rand = 1'b0; rr_hold = 0; fixed_ops = 1'b0;
    fix0 = '0; fix1 = '0; fix2 = '0;
    pend0 = '0; pend1 = '0; pend2 = '0;
    last_cru = '0; last_d0 = '0; last_st = '0;
    req_valid = 1'b0; req_mode = 1'b0; req_sign = 3'd0; req_update_st = 1'b0; req_len = 4'd0;
    opd_valid = 1'b0; opd_src0 = '0; opd_src1 = '0; opd_src2 = '0; res_ready = 1'b0;
    dst_reg0 = '0; dst_reg1 = '0; st = '0;
    rst = 1'b1;
    doReset();

    $display("[TB] 32-bit single beat with lane overflow");
    fixed_ops = 1'b1;
    fix0 = {4{32'h7FFF_FFFF}};
    fix1 = {4{32'h0000_0001}};
    fix2 = rnd128();
    runRequest(1'b1, 3'b111, 1'b1, 4'd1, 100);
    checkOutput("t1_cru", last_cru, 11'b1_11_11_11_110_1);
    checkOutput("t1_dst0", last_d0, {4{32'h8000_0000}});
    checkOutput("t1_st_lane0", last_st[31:0], 32'h0000_0001);
    checkOutput("t1_req_ready", req_ready, 1'b1);
    fixed_ops = 1'b0;

    $display("[TB] 4+8-bit four beats back to back");
    b = dut_beats;
    runRequest(1'b0, 3'b101, 1'b0, 4'd4, 100);
    checkOutput("t2_beats", dut_beats - b, 4);
    checkOutput("t2_cru", last_cru, 11'b1_00_00_00_101_0);

    $display("[TB] credit stall with res_ready held low");
    b = dut_beats;
    rr_hold = 20;
    req_mode = 1'b0; req_sign = 3'b011; req_update_st = 1'b1; req_len = 4'd8;
    req_valid = 1'b1;
    n = 0;
    while (!active && n < 50) begin applyStimulus(); n++; end
    req_valid = 1'b0;
    while (rr_hold > 0) applyStimulus();
    checkOutput("t3_stall_beats", dut_beats - b, 4);
    checkOutput("t3_stall_opd_ready", opd_ready, 1'b0);
    n = 0;
    while (active && n < 100) begin applyStimulus(); n++; end
    checkOutput("t3_total_beats", dut_beats - b, 8);
    checkOutput("t3_busy", busy, 1'b0);

    $display("[TB] len=0 with gapped operands");
    opd_pat = 1;
    b = dut_beats;
    runRequest(1'b0, 3'b010, 1'b1, 4'd0, 200);
    checkOutput("t4_beats", dut_beats - b, 16);
    opd_pat = 0;

    $display("[TB] reset in the middle of a burst");
    req_mode = 1'b1; req_sign = 3'b110; req_update_st = 1'b0; req_len = 4'd6;
    req_valid = 1'b1;
    n = 0;
    while (!active && n < 50) begin applyStimulus(); n++; end
    req_valid = 1'b0;
    while (m_issued < 3 && n < 100) begin applyStimulus(); n++; end
    doReset();
    b = dut_beats;
    opd_pat = 2;
    for (int i = 0; i < 4; i++) applyStimulus();
    checkOutput("t5_no_late_beat", dut_beats - b, 0);
    opd_pat = 0;
    runRequest(1'b1, 3'b011, 1'b0, 4'd5, 100);

    $display("[TB] request held during a busy burst");
    req_mode = 1'b0; req_sign = 3'b110; req_update_st = 1'b0; req_len = 4'd3;
    req_valid = 1'b1;
    n = 0;
    while (!active && n < 50) begin applyStimulus(); n++; end
    req_mode = 1'b1; req_sign = 3'b101; req_update_st = 1'b1; req_len = 4'd2;
    while (active && n < 100) begin applyStimulus(); n++; end
    applyStimulus();
    checkOutput("t6_second_accept", busy, 1'b1);
    req_valid = 1'b0;
    while (active && n < 200) begin applyStimulus(); n++; end
    checkOutput("t6_cru", last_cru, 11'b1_11_11_11_100_1);
    checkOutput("t6_busy", busy, 1'b0);

    $display("[TB] randomized requests");
    opd_pat = 2;
    rr_rand = 1'b1;
    for (int r = 0; r < 6; r++) begin
      runRequest(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 400);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/intadd_cru_issuer.md
Name: intadd_cru_issuer

Overview:
Issue-side sequencer for the intadd unit. It accepts one vector-add request over a valid/ready handshake and streams operand triples from an operand interface. For each triple it presents one registered beat of src_reg0/1/2 plus the packed 11-bit cru_intadd microinstruction. It captures dst_reg0/dst_reg1/st after the unit latency and returns them in order through a credit-protected result FIFO.

Parameters:
INTADD_LAT, 1, cycles from a cru beat being presented to its dst_reg0/dst_reg1/st being valid (1..4)
RES_DEPTH, 4, result FIFO depth; also the maximum number of beats in flight plus buffered (2..16, power of 2)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req_valid  in  1  request valid
req_ready  out  1  request accepted when high together with req_valid
req_mode  in  1  0 = 4+8-bit three-source mode (precision 2'b00); 1 = 32-bit two-source mode (precision 2'b11)
req_sign  in  3  {sign_s0, sign_s1, sign_s2}
req_update_st  in  1  update_st field for every beat of the request
req_len  in  4  beats in the request; 0 means 16
opd_valid  in  1  operand triple valid
opd_ready  out  1  operand triple consumed when high together with opd_valid
opd_src0, opd_src1, opd_src2  in  128 each  operands
src_reg0, src_reg1, src_reg2  out  128 each  to intadd
cru_intadd  out  11  to intadd
dst_reg0, dst_reg1, st  in  128 each  from intadd
res_valid  out  1  result valid
res_ready  in  1  result consumer ready
res_dst0, res_dst1, res_st  out  128 each  result data
res_last  out  1  marks the final result of the request
busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (rst high at a clk edge):
  - state becomes IDLE; all counters, the valid pipe and the FIFO are cleared.
  - src_reg0/1/2, cru_intadd, res_* and busy are all 0.
  - A reset during a burst abandons it. No further cru beats or results are produced.
- cru_intadd packing: [10] inst_valid, [9:8] prec_s0, [7:6] prec_s1, [5:4] prec_s2, [3] sign_s0, [2] sign_s1, [1] sign_s2, [0] update_st.
  - 32-bit mode: all three precision fields = 2'b11; sign_s2 forced to 0.
  - 4+8-bit mode: all three precision fields = 2'b00.
  - On any cycle without a beat, cru_intadd = 11'd0. The src_reg outputs hold their last value.
- State machine:
  - IDLE: req_ready = 1. When req_valid is high, latch mode, sign, update_st and len (0 becomes 16), clear the issued counter, and go to ISSUE.
  - ISSUE: req_ready = 0. opd_ready = credit_ok, where credit_ok = (inflight + fifo_count < RES_DEPTH).
    - On an opd handshake, register the operands onto src_reg0/1/2 and cru_intadd (inst_valid = 1) for exactly the next cycle, then increment issued.
    - In 32-bit mode, opd_src2 is consumed and driven on src_reg2 but is don't-care to the unit.
    - When issued reaches len, go to DRAIN.
  - DRAIN: opd_ready = 0. Go to IDLE on the cycle the result carrying res_last is popped (res_valid && res_ready && res_last).
  - opd_ready is 0 in IDLE and DRAIN.
- Capture path:
  - A shift pipe of INTADD_LAT valid bits, with a parallel last flag, tracks each presented beat.
  - When a beat's tail bit is set, sample dst_reg0, dst_reg1 and st at that edge and push them, with the last flag, into the FIFO.
  - Timing: a beat presented in cycle t is sampled at the end of cycle t+INTADD_LAT. res_valid rises no earlier than cycle t+INTADD_LAT+1.
- Result FIFO:
  - res_* are driven from the FIFO head; res_valid = !empty.
  - Data is stable while res_valid && !res_ready.
  - Results leave in issue order.
- Credit accounting:
  - inflight counts beats issued and not yet pushed into the FIFO; fifo_count counts beats pushed and not yet popped.
  - The credit rule guarantees the FIFO never overflows, so a push when full cannot occur.
  - Issue and pop in the same cycle leave the total unchanged. Push and pop in the same cycle leave fifo_count unchanged.
- Interface rules:
  - req_ready is never high outside IDLE. A new request may be accepted on the cycle after the last result is popped.
  - opd_valid may drop at any time; gaps produce no beats (cru_intadd = 0 during the gap).
  - res_ready held low stalls issue once RES_DEPTH beats are outstanding. Issue resumes on the cycle after a pop.

Test Plan:
- 32-bit, len=1, sign=3'b111, update_st=1, src0=4x7FFFFFFF, src1=4x00000001:
  - cru_intadd = 11'b1_11_11_11_110_1 for exactly one cycle.
  - One result matching the C reference model (lanes 80000000, overflow flagged in st); res_last = 1.
  - busy returns to 0; req_ready = 1.
- 4+8-bit, len=4, sign=3'b101, random operands, res_ready = 1:
  - Four beats with cru_intadd = 11'b1_00_00_00_101_0 on consecutive cycles.
  - Four in-order results; res_last set only on the 4th.
- 4+8-bit, len=8, res_ready held 0 for 20 cycles:
  - opd_ready drops after exactly RES_DEPTH=4 handshakes; no further beats.
  - After res_ready is released, the remaining 4 beats issue and all 8 results match the model in order.
- len=0 with opd_valid toggling every other cycle:
  - Exactly 16 beats are issued; cru_intadd = 0 on every gap cycle.
  - res_last appears on the 16th result.
- rst pulsed high for one cycle after 3 of 6 beats:
  - All outputs are 0 the next cycle; state is IDLE; res_valid = 0; no late push occurs.
  - A fresh request then completes normally.
- req_valid held high during a busy burst:
  - req_ready stays 0 until the last result pops.
  - The second request is accepted in IDLE on the following cycle and its beats carry the new mode and sign fields.
